// File: rtl/l3_refill_ctrl_if.sv
// rtl/l3_refill_ctrl_if.sv - main-memory req/ack bus between the L3 refill controller and memory
interface l3_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [3:0]            mem_byte_en_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_byte_en_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_byte_en_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/l3_refill_ctrl.sv
// rtl/l3_refill_ctrl.sv - L3 miss/refill and write-through controller (optional timeout: L3_REFILL_TIMEOUT_EN)
module l3_refill_ctrl #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] PENDING_DATA   = 32'hDEADBEEF,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  l3_req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [3:0]            byte_en_i,
    input  logic                  l3_cache_hit_i,
    l3_refill_ctrl_if.master      mem,
    output logic [DATA_WIDTH-1:0] main_mem_data_o,
    output logic                  stall_o,
    output logic                  timeout_o
);
    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  need;

    // A read hit is served by the L3 alone; misses and every store go to memory.
    assign need = l3_req_i & (wr_en_i | ~l3_cache_hit_i);

`ifdef L3_REFILL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    // Wait counter and the flag marking a FILL that follows an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    // Clear on REQ entry, count unacked REQ cycles, flag the abort on the last one.
    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (state_q == IDLE && need) begin
            cnt_d = '0;
            to_d  = 1'b0;
        end else if (state_q == REQ && !mem.mem_ack_i) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                to_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign timeout_o = (state_q == FILL) & to_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_o          = 1'b0;
`endif

    // State and latched transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state, latching and stall; DONE ignores l3_req_i so the retiring access cannot re-trigger.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = need;
                if (need) begin
                    addr_d  = addr_i;
                    we_d    = wr_en_i;
                    wdata_d = wr_data_i;
                    be_d    = byte_en_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (mem.mem_ack_i) begin
                    rdata_d = mem.mem_rdata_i;
                    state_d = FILL;
                end
`ifdef L3_REFILL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = FILL;
                end
`endif
            end
            FILL: begin
                stall_o = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill value toward the L3: read data, zero for stores, sentinel otherwise.
    always_comb begin
        main_mem_data_o = PENDING_DATA;
        if (state_q == FILL) begin
            main_mem_data_o = we_q ? '0 : rdata_q;
`ifdef L3_REFILL_TIMEOUT_EN
            if (to_q) begin
                main_mem_data_o = PENDING_DATA;
            end
`endif
        end
    end

    assign mem.mem_req_o     = (state_q == REQ);
    assign mem.mem_we_o      = (state_q == REQ) & we_q;
    assign mem.mem_addr_o    = addr_q;
    assign mem.mem_wdata_o   = wdata_q;
    assign mem.mem_byte_en_o = be_q;
endmodule
